// File: rtl/ldw_mem.sv
// ldw pipeline memory-access stage: EXE/MEM register, bus FSM, MEM/WB register.
// Ports: E-stage inputs, dmem req/ack bus, mem_stall, M/W forwarding outputs, bus_err.
module ldw_mem #(
   parameter int unsigned ACK_TIMEOUT = 255,
   parameter logic [31:0] ERR_DATA    = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        clrn,
   input  logic        ewreg,
   input  logic        em2reg,
   input  logic        ewmem,
   input  logic [31:0] ealu,
   input  logic [31:0] eb,
   input  logic [4:0]  ern,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   input  logic        dmem_ack,
   input  logic [31:0] dmem_rdata,
   output logic        mem_stall,
   output logic        mwreg,
   output logic        mm2reg,
   output logic [4:0]  mrn,
   output logic [31:0] malu,
   output logic        wwreg,
   output logic        wm2reg,
   output logic [4:0]  wrn,
   output logic [31:0] walu,
   output logic [31:0] wmo,
   output logic        bus_err
);

   localparam int CW = $clog2(ACK_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE,
      BUSY,
      DONE
   } state_t;

   state_t        state;
   logic [CW-1:0] cnt;
   logic          mwmem;
   logic [31:0]   mb;
   logic [31:0]   mdata;
   logic          memop;
   logic          tmo;

   assign memop = mm2reg | mwmem;
   assign tmo   = (cnt == CW'(ACK_TIMEOUT - 1));

   // IDLE stalls as soon as a memop lands in M so EXE/MEM holds it
   assign mem_stall = (state == BUSY) |
                      ((state == IDLE) & memop);

   assign dmem_addr  = malu;
   assign dmem_wdata = mb;

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         mwreg  <= 1'b0;
         mm2reg <= 1'b0;
         mwmem  <= 1'b0;
         mrn    <= 5'd0;
         malu   <= 32'd0;
         mb     <= 32'd0;
      end else if (!mem_stall) begin
         mwreg  <= ewreg;
         mm2reg <= em2reg;
         mwmem  <= ewmem;
         mrn    <= ern;
         malu   <= ealu;
         mb     <= eb;
      end
   end

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         state    <= IDLE;
         cnt      <= '0;
         dmem_req <= 1'b0;
         dmem_we  <= 1'b0;
         mdata    <= 32'd0;
         bus_err  <= 1'b0;
      end else begin
         unique case (state)
            IDLE: begin
               cnt <= '0;
               if (memop) begin
                  state    <= BUSY;
                  dmem_req <= 1'b1;
                  dmem_we  <= mwmem;
               end
            end
            BUSY: begin
               cnt <= cnt + CW'(1);
               if (dmem_ack) begin
                  if (mm2reg) mdata <= dmem_rdata;
                  state    <= DONE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end else if (tmo) begin
                  mdata    <= ERR_DATA;
                  bus_err  <= 1'b1;
                  state    <= DONE;
                  dmem_req <= 1'b0;
                  dmem_we  <= 1'b0;
               end
            end
            DONE: begin
               cnt   <= '0;
               state <= IDLE;
            end
            default: begin
               state    <= IDLE;
               dmem_req <= 1'b0;
               dmem_we  <= 1'b0;
            end
         endcase
      end
   end

   // a stall cycle sends a bubble; the data fields just hold
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         wwreg  <= 1'b0;
         wm2reg <= 1'b0;
         wrn    <= 5'd0;
         walu   <= 32'd0;
         wmo    <= 32'd0;
      end else if (!mem_stall) begin
         wwreg  <= mwreg;
         wm2reg <= mm2reg;
         wrn    <= mrn;
         walu   <= malu;
         wmo    <= mm2reg ? mdata : 32'd0;
      end else begin
         wwreg  <= 1'b0;
         wm2reg <= 1'b0;
      end
   end

endmodule

// File: tb/tb_ldw_mem.sv
// Self-checking bench for ldw_mem: transaction model with random bus delays.
// Drives instruction stream and a bus responder; checks every cycle.
module tb_ldw_mem;

   localparam int          TO  = 4;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic        clk = 1'b0;
   logic        clrn;
   logic        ewreg, em2reg, ewmem;
   logic [31:0] ealu, eb;
   logic [4:0]  ern;
   logic        dmem_req, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata;
   logic        dmem_ack;
   logic [31:0] dmem_rdata;
   logic        mem_stall;
   logic        mwreg, mm2reg;
   logic [4:0]  mrn;
   logic [31:0] malu;
   logic        wwreg, wm2reg;
   logic [4:0]  wrn;
   logic [31:0] walu, wmo;
   logic        bus_err;

   ldw_mem #(.ACK_TIMEOUT(TO), .ERR_DATA(ERR)) dut (
      .clk(clk), .clrn(clrn),
      .ewreg(ewreg), .em2reg(em2reg), .ewmem(ewmem),
      .ealu(ealu), .eb(eb), .ern(ern),
      .dmem_req(dmem_req), .dmem_we(dmem_we),
      .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
      .mem_stall(mem_stall),
      .mwreg(mwreg), .mm2reg(mm2reg), .mrn(mrn), .malu(malu),
      .wwreg(wwreg), .wm2reg(wm2reg), .wrn(wrn),
      .walu(walu), .wmo(wmo), .bus_err(bus_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        wreg, m2reg, wmem;
      logic [4:0]  rn;
      logic [31:0] alu, b;
      int          d;
   } ins_t;

   ins_t q[$];
   ins_t cur;
   int   cyc;
   logic [31:0] cur_rd;
   logic wb_wreg, wb_m2reg, wb_v, err_e;
   logic [4:0]  wb_rn;
   logic [31:0] wb_alu, wb_mo;
   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t",
                  tag, got, exp, $time);
      end
   endtask

   function automatic ins_t mk(input logic w, input logic l,
                               input logic s, input logic [4:0] rn,
                               input logic [31:0] a, input logic [31:0] b,
                               input int d);
      ins_t i;
      i.wreg = w; i.m2reg = l; i.wmem = s;
      i.rn = rn; i.alu = a; i.b = b; i.d = d;
      return i;
   endfunction

   function automatic ins_t rnd();
      int k;
      k = $urandom_range(2, 0);
      case (k)
         0: return mk(1, 0, 0, 5'($urandom), $urandom, $urandom, 0);
         1: return mk(1, 1, 0, 5'($urandom), $urandom, $urandom,
                      $urandom_range(5, 0));
         default: return mk(0, 0, 1, 5'($urandom), $urandom, $urandom,
                            $urandom_range(5, 0));
      endcase
   endfunction

   task automatic model_reset();
      cur = mk(0, 0, 0, 0, 0, 0, 0);
      cyc = 0;
      cur_rd = 0;
      wb_wreg = 0; wb_m2reg = 0; wb_v = 1;
      wb_rn = 0; wb_alu = 0; wb_mo = 0;
      err_e = 0;
   endtask

   task automatic drive(input ins_t i);
      ewreg = i.wreg; em2reg = i.m2reg; ewmem = i.wmem;
      ern = i.rn; ealu = i.alu; eb = i.b;
   endtask

   task automatic cycle();
      ins_t n;
      logic mop, stall_e, req_e, ack, tmo;
      int busy, lat;
      logic [31:0] rd;
      @(negedge clk);
      mop  = cur.m2reg | cur.wmem;
      tmo  = mop && (cur.d >= TO);
      busy = !mop ? 0 : (tmo ? TO : cur.d + 1);
      lat  = mop ? busy + 2 : 1;
      stall_e = (cyc < lat - 1);
      req_e   = mop && (cyc >= 1) && (cyc <= busy);
      chk("mem_stall", mem_stall, stall_e);
      chk("dmem_req", dmem_req, req_e);
      if (req_e) begin
         chk("dmem_we", dmem_we, cur.wmem);
         chk("dmem_addr", dmem_addr, cur.alu);
         chk("dmem_wdata", dmem_wdata, cur.b);
      end
      chk("mwreg", mwreg, cur.wreg);
      chk("mm2reg", mm2reg, cur.m2reg);
      chk("mrn", mrn, cur.rn);
      chk("malu", malu, cur.alu);
      chk("wwreg", wwreg, wb_wreg);
      chk("wm2reg", wm2reg, wb_m2reg);
      if (wb_v) begin
         chk("wrn", wrn, wb_rn);
         chk("walu", walu, wb_alu);
         chk("wmo", wmo, wb_mo);
      end
      chk("bus_err", bus_err, err_e);
      rd = $urandom;
      if (req_e) ack = !tmo && (cyc == cur.d + 1);
      else ack = ($urandom_range(3, 0) == 0);
      if (req_e && ack) cur_rd = rd;
      dmem_ack = ack;
      dmem_rdata = rd;
      if (req_e && tmo && cyc == TO) err_e = 1;
      if (stall_e) begin
         wb_wreg = 0; wb_m2reg = 0; wb_v = 0;
         drive(mk($urandom, $urandom, $urandom, 5'($urandom),
                  $urandom, $urandom, 0));
         cyc++;
      end else begin
         wb_wreg = cur.wreg; wb_m2reg = cur.m2reg; wb_v = 1;
         wb_rn = cur.rn; wb_alu = cur.alu;
         wb_mo = !cur.m2reg ? 32'd0 : (tmo ? ERR : cur_rd);
         if (q.size() > 0) n = q.pop_front();
         else n = mk(0, 0, 0, 0, 0, 0, 0);
         drive(n);
         cur = n;
         cyc = 0;
         cur_rd = 0;
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (q.size() > 0 && g < 5000) begin
         cycle();
         g++;
      end
      chk("drain_bound", 32'(q.size()), 32'd0);
      repeat (8) cycle();
   endtask

   initial begin
      int g;
      clrn = 1'b0;
      drive(mk(0, 0, 0, 0, 0, 0, 0));
      dmem_ack = 1'b0;
      dmem_rdata = 32'd0;
      model_reset();
      #12;
      chk("rst_stall", mem_stall, 0);
      chk("rst_req", dmem_req, 0);
      chk("rst_we", dmem_we, 0);
      chk("rst_mwreg", mwreg, 0);
      chk("rst_mm2reg", mm2reg, 0);
      chk("rst_mrn", mrn, 0);
      chk("rst_malu", malu, 0);
      chk("rst_wwreg", wwreg, 0);
      chk("rst_wm2reg", wm2reg, 0);
      chk("rst_wrn", wrn, 0);
      chk("rst_walu", walu, 0);
      chk("rst_wmo", wmo, 0);
      chk("rst_bus_err", bus_err, 0);
      @(negedge clk);
      clrn = 1'b1;

      q.push_back(mk(1, 0, 0, 5, 32'h10, 0, 0));
      q.push_back(mk(1, 1, 0, 7, 32'h100, 0, 0));
      q.push_back(mk(0, 0, 1, 9, 32'h104, 32'h1234_5678, 3));
      q.push_back(mk(1, 1, 0, 1, 32'h200, 0, 0));
      q.push_back(mk(1, 1, 0, 2, 32'h204, 0, 0));
      q.push_back(mk(1, 1, 0, 3, 32'h208, 0, 2));
      drain();

      q.push_back(mk(1, 1, 0, 4, 32'h300, 0, 5));
      g = 0;
      while (!(cur.alu == 32'h300 && cur.m2reg && cyc == 2) && g < 50) begin
         cycle();
         g++;
      end
      chk("reach_busy", 32'(g < 50), 32'd1);
      #1 clrn = 1'b0;
      #1;
      chk("arst_req", dmem_req, 0);
      chk("arst_stall", mem_stall, 0);
      chk("arst_mwreg", mwreg, 0);
      chk("arst_wwreg", wwreg, 0);
      @(posedge clk);
      @(negedge clk);
      clrn = 1'b1;
      drive(mk(0, 0, 0, 0, 0, 0, 0));
      dmem_ack = 1'b0;
      model_reset();
      q.push_back(mk(1, 0, 0, 6, 32'h44, 0, 0));
      drain();

      q.push_back(mk(1, 1, 0, 8, 32'h400, 0, 9));
      q.push_back(mk(1, 1, 0, 10, 32'h404, 0, 0));
      drain();

      repeat (200) q.push_back(rnd());
      drain();

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end

endmodule

// File: doc/ldw_mem.md
Name: ldw_MEM

Overview:
- Memory-access stage of the ldw five-stage pipeline, directly downstream of the EXE stage.
- Contains the EXE/MEM pipeline register, a request/acknowledge data-bus FSM with timeout, and the MEM/WB pipeline register.
- Generates the pipeline-wide stall while a load or store is outstanding.
- Exports M-stage values for forwarding to ID.

Parameters:
- ACK_TIMEOUT, 255: cycles in BUSY without dmem_ack before the access is aborted.
- ERR_DATA, 32'h0000_0000: data returned to WB for a timed-out load.

Ports:
- clk  in  1  pipeline clock, rising edge
- clrn  in  1  asynchronous active-low reset
- ewreg  in  1  EXE instruction writes the register file
- em2reg  in  1  EXE instruction is a load
- ewmem  in  1  EXE instruction is a store
- ealu  in  32  EXE result / effective address
- eb  in  32  store data
- ern  in  5  destination register
- dmem_req  out  1  bus request
- dmem_we  out  1  1 = write, 0 = read
- dmem_addr  out  32  byte address (= malu)
- dmem_wdata  out  32  store data (= mb)
- dmem_ack  in  1  bus acknowledge; rdata valid in the same cycle
- dmem_rdata  in  32  read data
- mem_stall  out  1  freeze PC, IF/ID, ID/EXE and EXE/MEM
- mwreg, mm2reg  out  1 each  M-stage controls, for forwarding
- mrn  out  5  M-stage destination, for forwarding
- malu  out  32  M-stage ALU result, for forwarding
- wwreg, wm2reg  out  1 each  WB controls
- wrn  out  5  WB destination
- walu  out  32  WB ALU result
- wmo  out  32  WB memory data
- bus_err  out  1  sticky timeout flag

Behaviour:
- Reset (clrn=0, asynchronous):
  - All pipeline registers clear: mwreg, mm2reg, mwmem, mrn, malu, mb, wwreg, wm2reg, wrn, walu and wmo are 0.
  - FSM goes to IDLE, the timeout counter clears, and bus_err=0.
  - dmem_req, dmem_we and mem_stall are 0 immediately.
  - Reset during BUSY abandons the access; no retry occurs after reset.
- EXE/MEM register:
  - When mem_stall=0, it loads ewreg, em2reg, ewmem, ern, ealu and eb on the rising edge.
  - When mem_stall=1, it holds.
- memop = mm2reg | mwmem.
- FSM states:
  - IDLE: if memop, mem_stall=1 and the next state is BUSY. Otherwise mem_stall=0 and the FSM stays in IDLE.
  - BUSY: dmem_req=1, dmem_we=mwmem, mem_stall=1, and the counter increments each cycle.
    - If dmem_ack: latch dmem_rdata (loads only) into the data register; next state is DONE.
    - Else if counter reaches ACK_TIMEOUT-1: latch ERR_DATA, set bus_err; next state is DONE.
    - dmem_ack and timeout in the same cycle: the ack takes priority, and bus_err is not set.
  - DONE: mem_stall=0 and dmem_req=0; the counter clears; next state is IDLE.
- Memory-op latency is 3 cycles in M minimum (IDLE, BUSY with ack, DONE), which is 2 stall cycles. Each extra cycle of ack delay adds one stall cycle.
- Non-memory instructions pass through M in 1 cycle with no stall.
- dmem_ack outside BUSY is ignored.
- Bus outputs are stable for the whole of BUSY. dmem_addr is not aligned or modified.
- MEM/WB register:
  - When mem_stall=0, it loads mwreg, mm2reg, mrn and malu. wmo takes the latched data for loads and 0 otherwise.
  - When mem_stall=1, it loads a bubble: wwreg=0 and wm2reg=0; other fields are don't-care but are held.
- A store never sets wwreg.
- bus_err stays at 1 until reset.

Test Plan:
- ALU instr (ewreg=1, ern=5, ealu=32'h10) -> mem_stall never 1; wwreg=1, wrn=5, walu=32'h10 two edges after issue.
- Load, ealu=32'h100, ack in the first BUSY cycle with rdata=32'hCAFE_0001 -> dmem_req high for 1 cycle, dmem_we=0, dmem_addr=32'h100, mem_stall high for 2 cycles, then wm2reg=1 and wmo=32'hCAFE_0001; the preceding bubble has wwreg=0.
- Store, eb=32'h1234_5678, ack delayed 3 cycles -> dmem_we=1, dmem_wdata stable for 4 BUSY cycles, mem_stall high for 5 cycles, wwreg=0 afterwards.
- Load, no ack, ACK_TIMEOUT=4 -> dmem_req high for exactly 4 cycles, then bus_err=1 and wmo=ERR_DATA; a following load with a normal ack completes and bus_err stays 1.
- clrn pulsed low during BUSY -> dmem_req, mem_stall, mwreg and wwreg drop to 0 without waiting for a clock; after release, an ALU instr flows normally.
- Back-to-back loads (addresses 32'h200, 32'h204), both acked immediately -> two separate BUSY phases, 4 stall cycles total, WB values in order.
